// File: rtl/spi_cnt_tx_slave_pkg.sv
// Shared definitions for the frequency-counter SPI transmit slave:
// frame geometry, FSM encoding and the frame checksum.
package spi_cnt_tx_slave_pkg;

   localparam int         FRAME_BITS  = 80;
   localparam int         BODY_BITS   = FRAME_BITS - 8;
   localparam int         BIT_CNT_W   = 7;
   localparam logic [3:0] HDR_NIB_DEF = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // XOR of every byte of the header + payload; the result is the trailing frame byte.
   function automatic logic [7:0] frame_csum(input logic [BODY_BITS-1:0] body);
      logic [7:0] acc;
      acc = '0;
      for (int i = 0; i < BODY_BITS / 8; i++) begin
         acc = acc ^ body[i*8 +: 8];
      end
      return acc;
   endfunction

endpackage

// File: rtl/spi_cnt_tx_slave_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous SPI pin, with one history flop
// producing single-cycle rise/fall pulses on the synchronised level.
module sync_edge_det #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              hist_q;
   logic              level;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         hist_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], sig_i};
         hist_q <= sync_q[STAGES-1];
      end
   end

   assign level  = sync_q[STAGES-1];
   assign rise_o = level & ~hist_q;
   assign fall_o = ~level & hist_q;

endmodule

// File: rtl/spi_cnt_tx_slave.sv
// SPI mode-0 read-only slave that serialises the latest fs/fx count pair as an
// 80-bit frame: header, fs word, fx word, XOR checksum, MSB first.
//
// state | meaning
// IDLE  | deselected, MISO low, new counts go straight to shadow
// LOAD  | one cycle: build frame from shadow, present first bit
// SHIFT | advance on synchronised SCK edges until nCS rises
// DONE  | one cycle: retire fresh flag, merge pending counts
module spi_cnt_tx_slave
   import spi_cnt_tx_slave_pkg::*;
#(
   parameter int         DATA_W      = 32,
   parameter int         SYNC_STAGES = 2,
   parameter logic [3:0] HDR_NIB     = HDR_NIB_DEF
) (
   input  logic              sys_clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] fs_cnt,
   input  logic [DATA_W-1:0] fx_cnt,
   input  logic              cnt_valid,
   input  logic              nCS,
   input  logic              SCK,
   output logic              MISO,
   output logic              busy,
   output logic              fresh
);

   localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_BITS);

   logic sck_rise, sck_fall, ncs_rise, ncs_fall;

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_sck (
      .clk_i  (sys_clk),
      .rst_ni (rst_n),
      .sig_i  (SCK),
      .rise_o (sck_rise),
      .fall_o (sck_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_ncs (
      .clk_i  (sys_clk),
      .rst_ni (rst_n),
      .sig_i  (nCS),
      .rise_o (ncs_rise),
      .fall_o (ncs_fall)
   );

   state_e                 state_q;
   logic [FRAME_BITS-1:0]  sr_q;
   logic [BIT_CNT_W-1:0]   bit_cnt_q;
   logic                   miso_q, busy_q, fresh_q, pend_vld_q;
   logic [DATA_W-1:0]      shd_fs_q, shd_fx_q, pend_fs_q, pend_fx_q;
   logic [BODY_BITS-1:0]   body_d;
   logic [FRAME_BITS-1:0]  frame_d;

   assign body_d  = {HDR_NIB, 3'b000, fresh_q, shd_fs_q, shd_fx_q};
   assign frame_d = {body_d, frame_csum(body_d)};

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sr_q       <= '0;
         bit_cnt_q  <= '0;
         miso_q     <= 1'b0;
         busy_q     <= 1'b0;
         fresh_q    <= 1'b0;
         pend_vld_q <= 1'b0;
         shd_fs_q   <= '0;
         shd_fx_q   <= '0;
         pend_fs_q  <= '0;
         pend_fx_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               miso_q <= 1'b0;
               if (ncs_fall) begin
                  state_q <= ST_LOAD;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD: begin
               sr_q      <= frame_d;
               bit_cnt_q <= '0;
               // a deselect landing on the load cycle must not be lost
               if (ncs_rise) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  miso_q  <= 1'b0;
               end else begin
                  state_q <= ST_SHIFT;
                  miso_q  <= frame_d[FRAME_BITS-1];
               end
            end
            ST_SHIFT: begin
               if (ncs_rise) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  miso_q  <= 1'b0;
               end else begin
                  if (sck_rise && bit_cnt_q != BIT_LAST) begin
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                  end
                  // zeros shifted in keep MISO low once the frame is exhausted
                  if (sck_fall) begin
                     sr_q   <= {sr_q[FRAME_BITS-2:0], 1'b0};
                     miso_q <= sr_q[FRAME_BITS-2];
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               miso_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               miso_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase

         // later assignments win: new counts beat a pending merge, which beats the read-clear
         if (state_q == ST_DONE) begin
            if (bit_cnt_q == BIT_LAST) begin
               fresh_q <= 1'b0;
            end
            if (pend_vld_q) begin
               shd_fs_q   <= pend_fs_q;
               shd_fx_q   <= pend_fx_q;
               fresh_q    <= 1'b1;
               pend_vld_q <= 1'b0;
            end
            if (cnt_valid) begin
               shd_fs_q <= fs_cnt;
               shd_fx_q <= fx_cnt;
               fresh_q  <= 1'b1;
            end
         end else if (state_q == ST_IDLE) begin
            if (cnt_valid) begin
               shd_fs_q <= fs_cnt;
               shd_fx_q <= fx_cnt;
               fresh_q  <= 1'b1;
            end
         end else if (cnt_valid) begin
            pend_fs_q  <= fs_cnt;
            pend_fx_q  <= fx_cnt;
            pend_vld_q <= 1'b1;
         end
      end
   end

   assign MISO  = miso_q;
   assign busy  = busy_q;
   assign fresh = fresh_q;

endmodule

// File: tb/tb_spi_cnt_tx_slave.sv
// Directed + randomised reads of spi_cnt_tx_slave checked against a
// byte-level model of the shadow/pending/fresh bookkeeping.
module tb_spi_cnt_tx_slave;

   localparam int HALF = 8;

   logic        sys_clk = 1'b0;
   logic        rst_n, cnt_valid, nCS, SCK;
   logic [31:0] fs_cnt, fx_cnt;
   logic        MISO, busy, fresh;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_fs, m_fx, p_fs, p_fx;
   bit          m_fresh, p_valid, in_txn;

   always #5 sys_clk = ~sys_clk;

   spi_cnt_tx_slave dut (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .fs_cnt    (fs_cnt),
      .fx_cnt    (fx_cnt),
      .cnt_valid (cnt_valid),
      .nCS       (nCS),
      .SCK       (SCK),
      .MISO      (MISO),
      .busy      (busy),
      .fresh     (fresh)
   );

   function automatic logic [79:0] exp_frame();
      logic [7:0] b [10];
      logic [79:0] f;
      b[0] = {4'hA, 3'b000, m_fresh};
      for (int i = 0; i < 4; i++) begin
         b[1+i] = m_fs[31-8*i -: 8];
         b[5+i] = m_fx[31-8*i -: 8];
      end
      b[9] = 8'h00;
      for (int i = 0; i < 9; i++) b[9] = b[9] ^ b[i];
      f = '0;
      for (int i = 0; i < 10; i++) f = {f[71:0], b[i]};
      return f;
   endfunction

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic pulse_valid(input logic [31:0] f, input logic [31:0] x);
      @(negedge sys_clk);
      fs_cnt = f; fx_cnt = x; cnt_valid = 1'b1;
      @(negedge sys_clk);
      cnt_valid = 1'b0;
      if (in_txn) begin
         p_fs = f; p_fx = x; p_valid = 1'b1;
      end else begin
         m_fs = f; m_fx = x; m_fresh = 1'b1;
      end
   endtask

   task automatic do_read(input string nm, input int nrise, input int inj,
                          input logic [31:0] inj_fs, input logic [31:0] inj_fx);
      logic [79:0] ef, cap;
      logic [15:0] ext;
      int          ne;
      ef = exp_frame();
      cap = '0; ext = '0; ne = 0;
      in_txn = 1'b1;
      nCS = 1'b0;
      cyc(HALF);
      for (int i = 0; i < nrise; i++) begin
         if (i < 80) cap = {cap[78:0], MISO};
         else begin
            ext = {ext[14:0], MISO};
            ne++;
         end
         SCK = 1'b1;
         if (i == 0) chk({nm, " busy_mid"}, 80'(busy), 80'(1));
         if (i == inj) begin
            pulse_valid(inj_fs, inj_fx);
            cyc(HALF - 2);
         end else begin
            cyc(HALF);
         end
         SCK = 1'b0;
         cyc(HALF);
      end
      nCS = 1'b1;
      in_txn = 1'b0;
      cyc(HALF);
      if (nrise >= 80) m_fresh = 1'b0;
      if (p_valid) begin
         m_fs = p_fs; m_fx = p_fx; m_fresh = 1'b1; p_valid = 1'b0;
      end
      if (nrise >= 80) begin
         chk({nm, " header"}, 80'(cap[79:72]), 80'(ef[79:72]));
         chk({nm, " fs"},     80'(cap[71:40]), 80'(ef[71:40]));
         chk({nm, " fx"},     80'(cap[39:8]),  80'(ef[39:8]));
         chk({nm, " csum"},   80'(cap[7:0]),   80'(ef[7:0]));
      end else begin
         chk({nm, " partial"}, cap, ef >> (80 - nrise));
      end
      if (ne > 0) chk({nm, " tail_zero"}, 80'(ext), 80'(0));
      chk({nm, " fresh_after"}, 80'(fresh), 80'(m_fresh));
      chk({nm, " busy_after"},  80'(busy),  80'(0));
      chk({nm, " miso_after"},  80'(MISO),  80'(0));
   endtask

   initial begin
      int sel, nr, inj;
      rst_n = 1'b0; nCS = 1'b1; SCK = 1'b0; cnt_valid = 1'b0;
      fs_cnt = '0; fx_cnt = '0;
      m_fs = '0; m_fx = '0; m_fresh = 1'b0;
      p_fs = '0; p_fx = '0; p_valid = 1'b0; in_txn = 1'b0;
      cyc(3);
      chk("rst miso",  80'(MISO),  80'(0));
      chk("rst busy",  80'(busy),  80'(0));
      chk("rst fresh", 80'(fresh), 80'(0));
      rst_n = 1'b1;
      cyc(6);

      pulse_valid(32'h0BEBC200, 32'h00989680);
      cyc(2);
      chk("capture fresh", 80'(fresh), 80'(m_fresh));
      chk("first header model", 80'(exp_frame() >> 72), 80'(8'hA1));
      do_read("rd1", 80, -1, '0, '0);
      do_read("rd2", 80, -1, '0, '0);
      do_read("rd3_inject", 80, 40, 32'd1, 32'd2);
      do_read("rd4", 80, -1, '0, '0);

      pulse_valid(32'h12345678, 32'h9ABCDEF0);
      cyc(4);
      do_read("abort20", 20, -1, '0, '0);
      do_read("after_abort", 80, -1, '0, '0);
      do_read("over88", 88, -1, '0, '0);

      // reset mid-read at bit 30
      in_txn = 1'b1;
      nCS = 1'b0;
      cyc(HALF);
      for (int i = 0; i < 30; i++) begin
         SCK = 1'b1; cyc(HALF);
         SCK = 1'b0; cyc(HALF);
      end
      rst_n = 1'b0;
      #1;
      chk("midrst miso",  80'(MISO),  80'(0));
      chk("midrst busy",  80'(busy),  80'(0));
      chk("midrst fresh", 80'(fresh), 80'(0));
      m_fs = '0; m_fx = '0; m_fresh = 1'b0; p_valid = 1'b0; in_txn = 1'b0;
      cyc(3);
      nCS = 1'b1;
      cyc(1);
      rst_n = 1'b1;
      cyc(10);
      chk("zero csum model", 80'(exp_frame()), {8'hA0, 64'h0, 8'hA0});
      do_read("post_rst", 80, -1, '0, '0);

      for (int r = 0; r < 6; r++) begin
         if ($urandom_range(0, 1) == 1) begin
            pulse_valid($urandom, $urandom);
            cyc(3);
         end
         sel = int'($urandom_range(0, 2));
         nr  = (sel == 0) ? 80 : (sel == 1) ? int'($urandom_range(1, 79))
                                            : int'($urandom_range(81, 90));
         inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, nr - 1)) : -1;
         do_read($sformatf("rnd%0d", r), nr, inj, $urandom, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
